nonce_collector: RTL and testbench

// - Sits between the two ava_rx nonce receivers and serial_transmit on USER_CLK.
// - Merges both chain nonce streams and drops duplicates against a short history.
// - Buffers accepted nonces in a FIFO, then drains them one word at a time to the USB UART.
// - Replaces the unbuffered send path and the latch-based dedup in the top level.

---
 rtl/nonce_collector_pkg.sv | 14 +
 rtl/nonce_fifo.sv | 74 +++++++
 rtl/nonce_collector.sv | 213 +++++++++++++++++++++
 tb/tb_nonce_collector.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_collector_pkg.sv
// Shared definitions for the nonce collector: data width and drain FSM states.
package nonce_collector_pkg;

    localparam int NONCE_W = 32;

    // Drain FSM encoding, fixed so state values stay meaningful in waveforms.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } drain_state_e;

endpackage

// File: rtl/nonce_fifo.sv
// Synchronous FIFO for accepted nonces with a registered read port.
// Pointers carry one extra wrap bit so full and empty are told apart.
module nonce_fifo
    import nonce_collector_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NONCE_W-1:0]       din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [NONCE_W-1:0]       dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [NONCE_W-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [NONCE_W-1:0] dout_q, dout_d;
    logic               do_rd;
    logic               do_wr;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = dout_q;

    // Read is resolved before write, so a full FIFO still accepts a write
    // in a cycle where it is also being popped.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + PW'(do_wr);
        rd_ptr_d = rd_ptr_q + PW'(do_rd);
        dout_d   = dout_q;
        if (do_rd) begin
            dout_d = mem[rd_ptr_q[AW-1:0]];
        end
    end

    // Pointer and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array write port.
    // NOTE: the array is deliberately not reset; the pointers define which
    // entries are meaningful, and leaving it reset-free keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/nonce_collector.sv
// Merges the two chain nonce streams, drops recent duplicates, buffers the
// survivors and drains them one word at a time to the UART transmitter.
module nonce_collector
    import nonce_collector_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int HIST         = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     nonce_ready0,
    input  logic [NONCE_W-1:0]       nonce0,
    input  logic                     nonce_ready1,
    input  logic [NONCE_W-1:0]       nonce1,
    input  logic                     tx_busy,
    output logic                     tx_send,
    output logic [NONCE_W-1:0]       tx_word,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     hit0,
    output logic                     hit1
);

    localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

    // Pending capture slots, one per chain.
    logic               slot0_v_q, slot0_v_d;
    logic [NONCE_W-1:0] slot0_q,   slot0_d;
    logic               slot1_v_q, slot1_v_d;
    logic [NONCE_W-1:0] slot1_q,   slot1_d;

    // Accepted-nonce history, entry 0 is the newest.
    logic [NONCE_W-1:0] hist_q   [HIST];
    logic [NONCE_W-1:0] hist_d   [HIST];
    logic [HIST-1:0]    hist_v_q, hist_v_d;

    logic               overflow_q, overflow_d;

    // Drain FSM.
    drain_state_e       state_q, state_d;
    logic [TW-1:0]      cnt_q,   cnt_d;

    // Commit path and FIFO hookup.
    logic               commit_v;
    logic [NONCE_W-1:0] commit_d;
    logic               dup;
    logic               accept;
    logic               fifo_rd;
    logic               fifo_full;
    logic               fifo_empty;
    logic               drop0;
    logic               drop1;
    logic               lost;

    nonce_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (commit_d),
        .wr_en (accept),
        .rd_en (fifo_rd),
        .dout  (tx_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Pick the committing slot (chain 0 first) and compare it to history.
    // A flush discards pending slots, so nothing commits in that cycle.
    always_comb begin
        commit_v = !flush && (slot0_v_q || slot1_v_q);
        commit_d = slot0_v_q ? slot0_q : slot1_q;
        dup      = 1'b0;
        for (int i = 0; i < HIST; i++) begin
            if (hist_v_q[i] && (hist_q[i] == commit_d)) begin
                dup = 1'b1;
            end
        end
        accept = commit_v && !dup;
        hit0   = accept && slot0_v_q;
        hit1   = accept && !slot0_v_q;
        lost   = accept && fifo_full && !fifo_rd;
    end

    // Slot bookkeeping: a slot frees when it commits or on flush, and a
    // strobe that finds its slot still occupied is dropped.
    always_comb begin
        slot0_v_d = slot0_v_q;
        slot0_d   = slot0_q;
        slot1_v_d = slot1_v_q;
        slot1_d   = slot1_q;
        drop0     = 1'b0;
        drop1     = 1'b0;

        if (flush || (commit_v && slot0_v_q)) begin
            slot0_v_d = 1'b0;
        end
        if (flush || (commit_v && !slot0_v_q)) begin
            slot1_v_d = 1'b0;
        end

        if (nonce_ready0) begin
            if (slot0_v_d) begin
                drop0 = 1'b1;
            end else begin
                slot0_v_d = 1'b1;
                slot0_d   = nonce0;
            end
        end
        if (nonce_ready1) begin
            if (slot1_v_d) begin
                drop1 = 1'b1;
            end else begin
                slot1_v_d = 1'b1;
                slot1_d   = nonce1;
            end
        end
    end

    // History shift and sticky overflow flag.
    always_comb begin
        hist_d   = hist_q;
        hist_v_d = hist_v_q;
        if (flush) begin
            hist_v_d = '0;
        end else if (accept) begin
            for (int i = HIST - 1; i > 0; i--) begin
                hist_d[i]   = hist_q[i-1];
                hist_v_d[i] = hist_v_q[i-1];
            end
            hist_d[0]   = commit_d;
            hist_v_d[0] = 1'b1;
        end

        overflow_d = overflow_q;
        if (flush) begin
            overflow_d = 1'b0;
        end
        if (drop0 || drop1 || lost) begin
            overflow_d = 1'b1;
        end
    end

    // Drain FSM next state and outputs. A word whose busy never rises
    // within the timeout is treated as sent.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fifo_rd = 1'b0;
        tx_send = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    fifo_rd = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_send = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end else if (cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign overflow = overflow_q;

    // State registers for slots, history, overflow and the drain FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_v_q  <= 1'b0;
            slot0_q    <= '0;
            slot1_v_q  <= 1'b0;
            slot1_q    <= '0;
            hist_v_q   <= '0;
            for (int i = 0; i < HIST; i++) begin
                hist_q[i] <= '0;
            end
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
        end else begin
            slot0_v_q  <= slot0_v_d;
            slot0_q    <= slot0_d;
            slot1_v_q  <= slot1_v_d;
            slot1_q    <= slot1_d;
            hist_v_q   <= hist_v_d;
            hist_q     <= hist_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nonce_collector.sv
// Self-checking bench for nonce_collector: a per-cycle vector table for the
// capture/dedup path, hand-written sequences for drain and flush corners,
// and a scoreboard of expected transmitted words.
module tb_nonce_collector;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        nonce_ready0 = 1'b0;
    logic [31:0] nonce0 = '0;
    logic        nonce_ready1 = 1'b0;
    logic [31:0] nonce1 = '0;
    logic        tx_busy = 1'b0;
    logic        tx_send;
    logic [31:0] tx_word;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        hit0;
    logic        hit1;

    nonce_collector #(
        .DEPTH        (DEPTH),
        .HIST         (4),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .nonce_ready0 (nonce_ready0),
        .nonce0       (nonce0),
        .nonce_ready1 (nonce_ready1),
        .nonce1       (nonce1),
        .tx_busy      (tx_busy),
        .tx_send      (tx_send),
        .tx_word      (tx_word),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .hit0         (hit0),
        .hit1         (hit1)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard of words expected on tx_word, in send order.
    logic [31:0] sb [$];
    int          send_cnt  = 0;
    int          hit0_cnt  = 0;
    int          hit1_cnt  = 0;
    int          cyc       = 0;
    int          prev_send = 0;
    int          last_send = 0;

    // Output monitor: pops the scoreboard on each send, counts hit pulses.
    always @(negedge clk) begin
        cyc++;
        if (hit0) hit0_cnt++;
        if (hit1) hit1_cnt++;
        if (tx_send) begin
            send_cnt++;
            prev_send = last_send;
            last_send = cyc;
            if (sb.size() == 0) begin
                check("unexpected_send", tx_word, 32'hxxxx_xxxx);
            end else begin
                check("tx_word", tx_word, sb.pop_front());
            end
        end
    end

    // serial_transmit model: 0 = busy rises 2 cycles after send for 10
    // cycles, 1 = held busy, 2 = never busy.
    int busy_mode = 0;
    int busy_dly  = 0;
    int busy_len  = 0;
    always @(negedge clk) begin
        if (busy_mode == 1) begin
            busy_dly = 0; busy_len = 0; tx_busy = 1'b1;
        end else if (busy_mode == 2) begin
            busy_dly = 0; busy_len = 0; tx_busy = 1'b0;
        end else begin
            if (tx_send) begin
                busy_dly = 2;
            end else if (busy_dly > 0) begin
                busy_dly--;
                if (busy_dly == 0) busy_len = 10;
            end else if (busy_len > 0) begin
                busy_len--;
            end
            tx_busy = (busy_dly == 0) && (busy_len > 0);
        end
    end

    typedef struct {
        logic        r0;
        logic [31:0] n0;
        logic        r1;
        logic [31:0] n1;
        logic        p0v;   // expected sends queued by this row
        logic [31:0] p0;
        logic        p1v;
        logic [31:0] p1;
        logic        e_hit0; // outputs seen in the cycle after this row
        logic        e_hit1;
        logic        e_ovf;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || fifo_level != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, 32'(sb.size() == 0 && fifo_level == 0), 32'd1);
        repeat (16) @(negedge clk);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic strobe(input logic ch, input logic [31:0] n);
        if (ch == 1'b0) begin nonce_ready0 = 1'b1; nonce0 = n; end
        else            begin nonce_ready1 = 1'b1; nonce1 = n; end
        @(negedge clk);
        nonce_ready0 = 1'b0;
        nonce_ready1 = 1'b0;
    endtask

    initial begin
        int base_s, base_h0, base_h1, n;

        //                r0    n0            r1    n1            p0v   p0            p1v   p1            h0    h1    ovf
        vecs[0]  = '{1'b1, 32'h1234_5678, 1'b0, 32'h0,        1'b1, 32'h1234_5678, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'hAAAA_0001, 1'b1, 32'hBBBB_0002, 1'b1, 32'hAAAA_0001, 1'b1, 32'hBBBB_0002, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0042, 1'b1, 32'h0000_0042, 1'b1, 32'h0000_0042, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,         1'b1, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'hCAFE_0001, 1'b0, 32'h0,        1'b1, 32'hCAFE_0001, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,         1'b1, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'hAAAA_0001, 1'b0, 32'h0,        1'b1, 32'hAAAA_0001, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'hCAFE_0001, 1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h5555_5555, 1'b0, 32'h0,        1'b1, 32'h5555_5555, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 32'h6666_6666, 1'b0, 32'h0,        1'b1, 32'h6666_6666, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h7777_7777, 1'b1, 32'h8888_8888, 1'b1, 32'h7777_7777, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 32'h7777_7778, 1'b1, 32'h9999_9999, 1'b1, 32'h7777_7778, 1'b1, 32'h8888_8888, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b1, 1'b1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx_send",  32'(tx_send),    32'd0);
        check("rst_tx_word",  tx_word,         32'd0);
        check("rst_level",    32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_hits",     32'({hit0, hit1}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table: capture, arbitration, dedup and slot overflow.
        base_s = send_cnt;
        for (int i = 0; i < NV; i++) begin
            nonce_ready0 = vecs[i].r0; nonce0 = vecs[i].n0;
            nonce_ready1 = vecs[i].r1; nonce1 = vecs[i].n1;
            if (vecs[i].p0v) sb.push_back(vecs[i].p0);
            if (vecs[i].p1v) sb.push_back(vecs[i].p1);
            @(negedge clk);
            nonce_ready0 = 1'b0;
            nonce_ready1 = 1'b0;
            check($sformatf("row%0d_hit0", i), 32'(hit0),     32'(vecs[i].e_hit0));
            check($sformatf("row%0d_hit1", i), 32'(hit1),     32'(vecs[i].e_hit1));
            check($sformatf("row%0d_ovf", i),  32'(overflow), 32'(vecs[i].e_ovf));
        end
        wait_drain("table");
        check("table_sends", 32'(send_cnt - base_s), 32'd12);
        pulse_flush();
        check("flush_clears_ovf", 32'(overflow), 32'd0);

        // Repeated nonce on chain 1, flush re-arms it.
        base_s  = send_cnt;
        base_h1 = hit1_cnt;
        sb.push_back(32'hDEAD_BEEF);
        for (int k = 0; k < 3; k++) begin
            strobe(1'b1, 32'hDEAD_BEEF);
            repeat (2) @(negedge clk);
        end
        check("dup_hit1_once", 32'(hit1_cnt - base_h1), 32'd1);
        pulse_flush();
        sb.push_back(32'hDEAD_BEEF);
        strobe(1'b1, 32'hDEAD_BEEF);
        repeat (2) @(negedge clk);
        check("dup_hit1_after_flush", 32'(hit1_cnt - base_h1), 32'd2);
        check("dup_no_ovf", 32'(overflow), 32'd0);
        wait_drain("dup");
        check("dup_sends", 32'(send_cnt - base_s), 32'd2);

        // FIFO fill while the transmitter is held busy.
        busy_mode = 1;
        repeat (2) @(negedge clk);
        base_s  = send_cnt;
        base_h0 = hit0_cnt;
        for (int k = 0; k < 20; k++) begin
            if (k < DEPTH) sb.push_back(32'h4000_0000 + 32'(k));
            strobe(1'b0, 32'h4000_0000 + 32'(k));
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check("full_level",    32'(fifo_level),           32'd16);
        check("full_overflow", 32'(overflow),             32'd1);
        check("full_hits",     32'(hit0_cnt - base_h0),   32'd20);
        busy_mode = 0;
        wait_drain("full");
        check("full_sends",    32'(send_cnt - base_s),    32'd16);
        pulse_flush();
        check("full_flush_ovf", 32'(overflow), 32'd0);

        // Busy never rises: timeout releases the FSM.
        busy_mode = 2;
        base_s = send_cnt;
        sb.push_back(32'h5000_0001);
        sb.push_back(32'h5000_0002);
        strobe(1'b0, 32'h5000_0001);
        strobe(1'b0, 32'h5000_0002);
        wait_drain("timeout");
        check("timeout_sends", 32'(send_cnt - base_s),  32'd2);
        check("timeout_gap",   32'(last_send - prev_send), 32'd6);

        // Asynchronous reset while waiting for busy to fall.
        busy_mode = 0;
        base_s = send_cnt;
        sb.push_back(32'h6000_0001);
        strobe(1'b0, 32'h6000_0001);
        strobe(1'b0, 32'h6000_0002);
        n = 0;
        while (send_cnt == base_s && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_seq_sent", 32'(send_cnt - base_s), 32'd1);
        repeat (6) @(negedge clk);
        check("pre_rst_busy",  32'(tx_busy),    32'd1);
        check("pre_rst_level", 32'(fifo_level), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tx_send", 32'(tx_send),    32'd0);
        check("arst_tx_word", tx_word,         32'd0);
        check("arst_level",   32'(fifo_level), 32'd0);
        check("arst_ovf",     32'(overflow),   32'd0);
        check("arst_hits",    32'({hit0, hit1}), 32'd0);
        busy_mode = 2;
        @(negedge clk);
        rst_n = 1'b1;
        base_s = send_cnt;
        repeat (20) @(negedge clk);
        check("post_rst_quiet", 32'(send_cnt - base_s), 32'd0);
        check("sb_empty",       32'(sb.size()),          32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
